stage_ex: RTL

Execute stage of the 5-stage MIPS pipeline: the consumer of the ID/EX register produced by `stage_id`. It computes ALU results, resolves branches and jumps, selects the destination register and registers everything into the EX/MEM boundary. It also holds an iterative signed multiply/divide unit with HI/LO registers and raises a stall toward IF/ID while that unit is busy.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/stage_ex_muldiv_unit.sv | 90 +++++++++
 rtl/stage_ex.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU opcodes, write-back bit positions, bubble constants
// and the multiply/divide FSM state type for the execute stage.
package mips_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_MULT = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;
    localparam logic [3:0] ALU_MFHI = 4'd13;
    localparam logic [3:0] ALU_MFLO = 4'd14;
    localparam logic [3:0] ALU_PASS = 4'd15;
    localparam int WBI_REGWRITE = 0;
    localparam int WBI_MEMTOREG = 1;
    localparam logic [31:0] BUBBLE_DATA = 32'd0;
    localparam logic [4:0]  BUBBLE_REG  = 5'd0;
    localparam logic [1:0]  BUBBLE_WBI  = 2'b00;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
endpackage

// File: rtl/stage_ex_muldiv_unit.sv
// muldiv_unit: iterative signed multiply (shift-add) and divide (restoring)
// on operand magnitudes, sign-corrected on the final iteration into HI/LO.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    localparam int CW = $clog2(CYCLES) + 1;
    md_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic        r_div, r_neg_q, r_neg_r;
    logic [63:0] r_acc, r_mc;
    logic [31:0] r_y, r_b, r_hi, r_lo;
    logic [31:0] w_ua, w_ub, w_rem, w_q, w_hi_n, w_lo_n;
    logic [63:0] w_acc_m, w_prod;
    logic [32:0] w_sh, w_diff;
    assign w_ua    = i_a[31] ? -i_a : i_a;
    assign w_ub    = i_b[31] ? -i_b : i_b;
    assign w_acc_m = r_acc + (r_y[0] ? r_mc : 64'd0);
    // Divider: r_acc[31:0] is the partial remainder, r_y shifts dividend out and quotient in.
    assign w_sh    = {r_acc[31:0], r_y[31]};
    assign w_diff  = w_sh - {1'b0, r_b};
    assign w_rem   = w_diff[32] ? w_sh[31:0] : w_diff[31:0];
    assign w_q     = {r_y[30:0], ~w_diff[32]};
    assign w_prod  = r_neg_q ? -w_acc_m : w_acc_m;
    assign w_hi_n  = r_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[63:32];
    assign w_lo_n  = r_div ? (r_neg_q ? -w_q : w_q) : w_prod[31:0];
    assign o_busy  = reset & ((r_state == MD_IDLE && i_start) || r_state == MD_BUSY);
    assign o_done  = r_state == MD_DONE;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_acc   <= '0;
            r_mc    <= '0;
            r_y     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                MD_IDLE: if (i_start) begin
                    r_div   <= i_op;
                    r_neg_q <= i_a[31] ^ i_b[31];
                    r_neg_r <= i_a[31];
                    r_acc   <= '0;
                    r_mc    <= {32'd0, w_ua};
                    r_y     <= i_op ? w_ua : w_ub;
                    r_b     <= w_ub;
                    r_cnt   <= CW'(CYCLES - 1);
                    if (i_op && i_b == 32'd0) begin
                        r_hi    <= i_a;
                        r_lo    <= '1;
                        r_state <= MD_DONE;
                    end else begin
                        r_state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    r_acc <= r_div ? {32'd0, w_rem} : w_acc_m;
                    r_mc  <= r_mc << 1;
                    r_y   <= r_div ? w_q : r_y >> 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_hi    <= w_hi_n;
                        r_lo    <= w_lo_n;
                        r_state <= MD_DONE;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/stage_ex.sv
// stage_ex: MIPS execute stage - ALU, branch resolution, destination select,
// multiply/divide with stall, and the EX/MEM pipeline register.
module stage_ex
    import mips_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_ex,
    input  logic [3:0]  aluOp,
    input  logic        isJump,
    input  logic        isNotConditional,
    input  logic        isEq,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [1:0]  wbi,
    input  logic        aluSrc,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [31:0] extendedInstr,
    input  logic [4:0]  regAddr1,
    input  logic [4:0]  regAddr2,
    input  logic        regDst,
    output logic        ex_stall,
    output logic [31:0] aluResult,
    output logic [31:0] storeData,
    output logic [4:0]  writeRegAddr,
    output logic        memWrite_mem,
    output logic        memRead_mem,
    output logic [1:0]  wbi_mem,
    output logic        branchTaken,
    output logic [31:0] branchTarget,
    output logic [31:0] pc_mem
);
    logic [31:0] w_b, w_alu, w_hi, w_lo;
    logic [4:0]  w_shamt;
    logic        w_md_op, w_md_done, w_bubble, w_taken;
    assign w_b      = aluSrc ? extendedInstr : reg2;
    assign w_shamt  = extendedInstr[10:6];
    assign w_md_op  = aluOp == ALU_MULT || aluOp == ALU_DIV;
    assign w_taken  = isJump & (isNotConditional | (isEq == (reg1 == reg2)));
    // MULT/DIV never retire as real instructions, so they are bubbles even once unstalled.
    assign w_bubble = ex_stall | w_md_done | w_md_op;
    muldiv_unit #(.CYCLES(MULDIV_CYCLES)) u_muldiv (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_md_op),
        .i_op    (aluOp == ALU_DIV),
        .i_a     (reg1),
        .i_b     (reg2),
        .o_busy  (ex_stall),
        .o_done  (w_md_done),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );
    always_comb begin
        w_alu = '0;
        case (aluOp)
            ALU_ADD:  w_alu = reg1 + w_b;
            ALU_SUB:  w_alu = reg1 - w_b;
            ALU_AND:  w_alu = reg1 & w_b;
            ALU_OR:   w_alu = reg1 | w_b;
            ALU_XOR:  w_alu = reg1 ^ w_b;
            ALU_NOR:  w_alu = ~(reg1 | w_b);
            ALU_SLT:  w_alu = {31'd0, $signed(reg1) < $signed(w_b)};
            ALU_SLL:  w_alu = w_b << w_shamt;
            ALU_SRL:  w_alu = w_b >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(w_b) >>> w_shamt);
            ALU_LUI:  w_alu = w_b << 16;
            ALU_MFHI: w_alu = w_hi;
            ALU_MFLO: w_alu = w_lo;
            ALU_PASS: w_alu = reg1;
            default:  w_alu = '0;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluResult    <= '0;
            storeData    <= '0;
            writeRegAddr <= '0;
            memWrite_mem <= 1'b0;
            memRead_mem  <= 1'b0;
            wbi_mem      <= '0;
            branchTaken  <= 1'b0;
            branchTarget <= '0;
            pc_mem       <= '0;
        end else begin
            aluResult    <= w_bubble ? BUBBLE_DATA : w_alu;
            storeData    <= w_bubble ? BUBBLE_DATA : reg2;
            writeRegAddr <= w_bubble ? BUBBLE_REG : (regDst ? regAddr2 : regAddr1);
            memWrite_mem <= ~w_bubble & memWrite;
            memRead_mem  <= ~w_bubble & memRead;
            wbi_mem      <= w_bubble ? BUBBLE_WBI : wbi;
            branchTaken  <= ~w_bubble & w_taken;
            branchTarget <= w_bubble ? BUBBLE_DATA : pc_ex + (extendedInstr << 2);
            pc_mem       <= w_bubble ? BUBBLE_DATA : pc_ex;
        end
    end
endmodule
